// File: rtl/deinterleaver.sv
// 802.11a single-stream bit deinterleaver (BPSK/QPSK) built on a two-bank ping-pong buffer.
// Bits are written in arrival order and read back column-by-column via row/column counters.
module deinterleaver #(
    parameter int unsigned N_CBPS = 48,
    parameter int unsigned N_COLS = 16,
    parameter int unsigned N_ROWS = N_CBPS / 16
) (
    input  logic Clock,
    input  logic Reset,
    input  logic In_Valid,
    input  logic Input,
    output logic In_Ready,
    output logic Out_Valid,
    output logic Output,
    output logic Out_First,
    output logic Out_Last,
    input  logic Out_Ready
);

    localparam int unsigned W_ADDR = $clog2(N_CBPS);
    localparam int unsigned W_ROW  = (N_ROWS > 1) ? $clog2(N_ROWS) : 1;
    localparam int unsigned W_COL  = $clog2(N_COLS);

    localparam logic [W_ADDR-1:0] LAST_ADDR = W_ADDR'(N_CBPS - 1);
    localparam logic [W_ADDR-1:0] ROW_STEP  = W_ADDR'(N_ROWS);
    localparam logic [W_ROW-1:0]  LAST_ROW  = W_ROW'(N_ROWS - 1);
    localparam logic [W_COL-1:0]  LAST_COL  = W_COL'(N_COLS - 1);

    generate
        if (!((N_CBPS == 48) || (N_CBPS == 96)) || (N_COLS != 16)) begin : g_bad_param
            $error("deinterleaver: N_CBPS must be 48 or 96 and N_COLS must be 16");
        end
    endgenerate

    logic [1:0][N_CBPS-1:0] r_bank;
    logic [1:0]             r_full;
    logic                   r_wsel;
    logic                   r_rsel;
    logic [W_ADDR-1:0]      r_wcnt;
    logic [W_ADDR-1:0]      r_raddr;
    logic [W_ROW-1:0]       r_row;
    logic [W_COL-1:0]       r_col;

    logic       w_wr_en;
    logic       w_rd_en;
    logic       w_wr_last;
    logic       w_col_last;
    logic       w_row_last;
    logic       w_rd_last;
    logic [1:0] w_full_nxt;

    assign w_wr_en    = In_Valid && !r_full[r_wsel];
    assign w_rd_en    = r_full[r_rsel] && Out_Ready;
    assign w_wr_last  = (r_wcnt == LAST_ADDR);
    assign w_col_last = (r_col == LAST_COL);
    assign w_row_last = (r_row == LAST_ROW);
    assign w_rd_last  = w_col_last && w_row_last;

    // A fill and a drain always target different banks, so both updates can land on one edge
    always_comb begin
        w_full_nxt = r_full;
        if (w_wr_en && w_wr_last) begin
            w_full_nxt[r_wsel] = 1'b1;
        end
        if (w_rd_en && w_rd_last) begin
            w_full_nxt[r_rsel] = 1'b0;
        end
    end

    always_ff @(posedge Clock) begin
        if (w_wr_en) begin
            r_bank[r_wsel][r_wcnt] <= Input;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_full <= '0;
            r_wsel <= 1'b0;
            r_wcnt <= '0;
        end else begin
            r_full <= w_full_nxt;
            if (w_wr_en) begin
                if (w_wr_last) begin
                    r_wcnt <= '0;
                    r_wsel <= !r_wsel;
                end else begin
                    r_wcnt <= r_wcnt + W_ADDR'(1);
                end
            end
        end
    end

    // Read address steps by N_ROWS along a row; a new row restarts at the row index
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_rsel  <= 1'b0;
            r_row   <= '0;
            r_col   <= '0;
            r_raddr <= '0;
        end else if (w_rd_en) begin
            if (w_col_last) begin
                r_col <= '0;
                if (w_row_last) begin
                    r_row   <= '0;
                    r_raddr <= '0;
                    r_rsel  <= !r_rsel;
                end else begin
                    r_row   <= r_row + W_ROW'(1);
                    r_raddr <= W_ADDR'(r_row) + W_ADDR'(1);
                end
            end else begin
                r_col   <= r_col + W_COL'(1);
                r_raddr <= r_raddr + ROW_STEP;
            end
        end
    end

    assign In_Ready  = !r_full[r_wsel];
    assign Out_Valid = r_full[r_rsel];
    assign Output    = Out_Valid && r_bank[r_rsel][r_raddr];
    assign Out_First = Out_Valid && (r_row == '0) && (r_col == '0);
    assign Out_Last  = Out_Valid && w_rd_last;

endmodule

// File: tb/tb_deinterleaver.sv
// Scoreboard bench for deinterleaver: one instance per supported symbol size (48 and 96 bits),
// expectations queued at stimulus time and popped by per-instance monitors.
module tb_deinterleaver;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst48 = 1'b1, iv48 = 1'b0, in48 = 1'b0, ordy48 = 1'b1;
    logic ir48, ov48, o48, of48, ol48;
    logic rst96 = 1'b1, iv96 = 1'b0, in96 = 1'b0, ordy96 = 1'b1;
    logic ir96, ov96, o96, of96, ol96;

    deinterleaver #(.N_CBPS(48)) u_dut48 (
        .Clock(clk), .Reset(rst48), .In_Valid(iv48), .Input(in48), .In_Ready(ir48),
        .Out_Valid(ov48), .Output(o48), .Out_First(of48), .Out_Last(ol48), .Out_Ready(ordy48)
    );

    deinterleaver #(.N_CBPS(96)) u_dut96 (
        .Clock(clk), .Reset(rst96), .In_Valid(iv96), .Input(in96), .In_Ready(ir96),
        .Out_Valid(ov96), .Output(o96), .Out_First(of96), .Out_Last(ol96), .Out_Ready(ordy96)
    );

    typedef struct packed {
        logic b;
        logic f;
        logic l;
    } exp_t;

    exp_t q48[$];
    exp_t q96[$];
    int   pop_cyc48[$];
    int   total = 0;
    int   bad = 0;
    int   pops48 = 0;
    int   pops96 = 0;
    int   cyc = 0;
    int   ir_drops = 0;
    bit   cont_mode = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor for the 48-bit instance
    always @(negedge clk) begin
        if (!rst48) begin
            if (ov48 && ordy48) begin
                if (q48.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL out48_unexpected: got valid output, expected none");
                end else begin
                    exp_t e;
                    e = q48.pop_front();
                    check("out48", 32'({o48, of48, ol48}), 32'(e));
                end
                pops48++;
                pop_cyc48.push_back(cyc);
            end else if (!ov48) begin
                check("idle48_zero", 32'({o48, of48, ol48}), 32'd0);
            end
            if (cont_mode && !ir48) ir_drops++;
        end
    end

    // Monitor for the 96-bit instance
    always @(negedge clk) begin
        if (!rst96) begin
            if (ov96 && ordy96) begin
                if (q96.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL out96_unexpected: got valid output, expected none");
                end else begin
                    exp_t e;
                    e = q96.pop_front();
                    check("out96", 32'({o96, of96, ol96}), 32'(e));
                end
                pops96++;
            end
        end
    end

    function automatic logic [95:0] deint(input logic [95:0] v, input int n);
        logic [95:0] r;
        int rows;
        r = '0;
        rows = n / 16;
        for (int k = 0; k < n; k++) r[k] = v[rows * (k % 16) + k / 16];
        return r;
    endfunction

    task automatic push_sym(input bit s96, input logic [95:0] e);
        int n;
        exp_t ent;
        n = s96 ? 96 : 48;
        for (int k = 0; k < n; k++) begin
            ent.b = e[k];
            ent.f = (k == 0);
            ent.l = (k == n - 1);
            if (s96) q96.push_back(ent);
            else     q48.push_back(ent);
        end
    endtask

    // Offer one bit and return just after the edge that accepts it
    task automatic send(input bit s96, input logic b);
        bit ok;
        ok = 1'b0;
        if (s96) begin iv96 = 1'b1; in96 = b; end
        else     begin iv48 = 1'b1; in48 = b; end
        for (int t = 0; t < 200 && !ok; t++) begin
            @(negedge clk);
            ok = s96 ? ir96 : ir48;
            @(posedge clk);
            #1;
        end
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL send_timeout: got In_Ready=0 for 200 cycles, expected acceptance");
        end
    endtask

    task automatic wait_drain(input bit s96);
        for (int t = 0; t < 1000 && (s96 ? q96.size() : q48.size()) != 0; t++) @(posedge clk);
        #1;
        check(s96 ? "drain96_left" : "drain48_left", 32'(s96 ? q96.size() : q48.size()), 32'd0);
    endtask

    logic [95:0] v, e, p0, p1, p2, sa, sb, ea;
    logic [99:0] pat;
    int acc, base, seen;

    initial begin
        repeat (2) @(posedge clk);
        #1;
        rst48 = 1'b0;
        rst96 = 1'b0;
        check("rst48_out_valid", 32'(ov48), 32'd0);
        check("rst48_output", 32'(o48), 32'd0);
        check("rst48_in_ready", 32'(ir48), 32'd1);
        check("rst48_first_last", 32'({of48, ol48}), 32'd0);
        check("rst96_in_ready", 32'(ir96), 32'd1);

        // Single 1 at i=3 lands at k=1
        v = '0; v[3] = 1'b1;
        e = '0; e[1] = 1'b1;
        push_sym(1'b0, e);
        for (int i = 0; i < 48; i++) begin
            send(1'b0, v[i]);
            if (i == 46) check("lat_not_early", 32'(ov48), 32'd0);
        end
        iv48 = 1'b0;
        check("lat_valid", 32'(ov48), 32'd1);
        check("lat_first", 32'(of48), 32'd1);
        wait_drain(1'b0);

        // Interleaved alternating pattern: bit i carries parity of floor(i/3)
        v = '0; e = '0;
        for (int i = 0; i < 48; i++) v[i] = 1'((i / 3) % 2);
        for (int k = 0; k < 48; k++) e[k] = 1'(k % 2);
        push_sym(1'b0, e);
        for (int i = 0; i < 48; i++) send(1'b0, v[i]);
        iv48 = 1'b0;
        wait_drain(1'b0);

        // Three back-to-back symbols with continuous handshakes
        p0 = 96'h0000_0000_0000_A5C3_0F1E_7B29;
        p1 = 96'h0000_0000_0000_1234_5678_9ABC;
        p2 = 96'h0000_0000_0000_FFFF_0000_F0F0;
        push_sym(1'b0, deint(p0, 48));
        push_sym(1'b0, deint(p1, 48));
        push_sym(1'b0, deint(p2, 48));
        base = pops48;
        cont_mode = 1'b1;
        for (int i = 0; i < 48; i++) send(1'b0, p0[i]);
        for (int i = 0; i < 48; i++) send(1'b0, p1[i]);
        for (int i = 0; i < 48; i++) send(1'b0, p2[i]);
        cont_mode = 1'b0;
        iv48 = 1'b0;
        check("cont_in_ready_drops", 32'(ir_drops), 32'd0);
        wait_drain(1'b0);
        check("cont_out_count", 32'(pops48 - base), 32'd144);
        if (pop_cyc48.size() >= base + 144)
            check("cont_contiguous", 32'(pop_cyc48[base + 143] - pop_cyc48[base]), 32'd143);

        // Backpressure: 100 bits offered with the sink stalled
        for (int i = 0; i < 100; i++) pat[i] = ((i * 7) % 5 == 0) || (i % 11 == 3);
        sa = '0; sb = '0;
        for (int i = 0; i < 48; i++) begin
            sa[i] = pat[i];
            sb[i] = pat[48 + i];
        end
        ea = deint(sa, 48);
        push_sym(1'b0, ea);
        push_sym(1'b0, deint(sb, 48));
        ordy48 = 1'b0;
        acc = 0;
        iv48 = 1'b1;
        for (int t = 0; t < 110 && acc < 100; t++) begin
            in48 = pat[acc];
            @(negedge clk);
            if (ir48) acc++;
            @(posedge clk);
            #1;
        end
        iv48 = 1'b0;
        check("stall_accepted", 32'(acc), 32'd96);
        check("stall_in_ready", 32'(ir48), 32'd0);
        check("stall_hold_first", 32'(of48), 32'd1);
        check("stall_hold_bit0", 32'(o48), 32'(ea[0]));
        ordy48 = 1'b1;
        base = pops48;
        seen = -1;
        for (int t = 0; t < 400 && pops48 < base + 96; t++) begin
            @(posedge clk);
            #1;
            if (seen < 0 && ir48) seen = pops48 - base;
        end
        check("refill_point", 32'(seen), 32'd48);
        wait_drain(1'b0);

        // Reset during readout discards the pending symbol
        ordy48 = 1'b0;
        for (int i = 0; i < 48; i++) send(1'b0, 1'b1);
        iv48 = 1'b0;
        check("pre_rst_valid", 32'(ov48), 32'd1);
        rst48 = 1'b1;
        @(posedge clk);
        #1;
        rst48 = 1'b0;
        ordy48 = 1'b1;
        check("mid_rst_valid", 32'({ov48, o48, of48}), 32'd0);
        check("mid_rst_in_ready", 32'(ir48), 32'd1);

        // 96-bit instance: partial symbol, reset, then one clean symbol
        for (int i = 0; i < 20; i++) send(1'b1, 1'b1);
        iv96 = 1'b0;
        rst96 = 1'b1;
        @(posedge clk);
        #1;
        rst96 = 1'b0;
        check("rst96_mid_valid", 32'(ov96), 32'd0);
        v = '0; v[6] = 1'b1;
        e = '0; e[1] = 1'b1;
        push_sym(1'b1, e);
        base = pops96;
        for (int i = 0; i < 96; i++) send(1'b1, v[i]);
        iv96 = 1'b0;
        wait_drain(1'b1);
        repeat (100) @(posedge clk);
        #1;
        check("sym96_count", 32'(pops96 - base), 32'd96);
        check("sym96_idle", 32'(ov96), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no completion, expected finish");
        $fatal(1);
    end

endmodule
